// File: rtl/whackamole_pkg.sv
// rtl/whackamole_pkg.sv - shared encodings for the whack-a-mole game sequencer
package whackamole_pkg;

    typedef enum logic [5:0] {
        IDLE = 6'b000001,
        GAP  = 6'b000010,
        PICK = 6'b000100,
        UP   = 6'b001000,
        HIT  = 6'b010000,
        DONE = 6'b100000
    } state_e;

    localparam logic [1:0] DIFF_EASY = 2'd0;
    localparam logic [1:0] DIFF_MED  = 2'd1;
    localparam logic [1:0] DIFF_HARD = 2'd2;

    localparam logic [3:0] LFSR_SEED = 4'b1011;
    localparam int         NUM_HOLES = 9;

    function automatic logic [6:0] sat_inc7(input logic [6:0] v);
        return (v == 7'h7F) ? v : v + 7'd1;
    endfunction

endpackage

// File: rtl/mole_tick_gen.sv
// rtl/mole_tick_gen.sv - millisecond prescaler; tick pulses on the last count of each period
module mole_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clr,
    output logic tick
);
    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/mole_scheduler.sv
// rtl/mole_scheduler.sv - whack-a-mole round sequencer: timer, mole cadence, random hole pick, scoring
module mole_scheduler
    import whackamole_pkg::*;
#(
    parameter int TICK_DIV  = 100000,
    parameter int GAME_MS   = 60000,
    parameter int GAP_MS    = 250,
    parameter int LIFE_EASY = 3000,
    parameter int LIFE_MED  = 2000,
    parameter int LIFE_HARD = 1000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Diff,
    input  logic        Ack,
    input  logic [8:0]  Sw,
    output logic        mole_valid,
    output logic [3:0]  mole_index,
    output logic [6:0]  score,
    output logic [6:0]  misses,
    output logic        game_active,
    output logic        game_done,
    output logic [15:0] ms_left
);
    state_e      state_q, state_d;
    logic [3:0]  lfsr_q, lfsr_d;
    logic [8:0]  sw_q;
    logic [6:0]  score_q, score_d;
    logic [6:0]  misses_q, misses_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] ms_q, ms_d;
    logic [15:0] gap_q, gap_d;
    logic [15:0] life_q, life_d;
    logic [15:0] life_sel_q, life_sel_d;
    logic        first_q, first_d;

    logic        tick;
    logic        tick_clr;
    logic        active;
    logic [8:0]  rise;
    logic [8:0]  hole_mask;
    logic        wrong_rise;
    logic        pick_ok;

    mole_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .Clk  (Clk),
        .Reset(Reset),
        .clr  (tick_clr),
        .tick (tick)
    );

    function automatic logic [15:0] life_for(input logic [1:0] d);
        case (d)
            DIFF_MED:  return 16'(LIFE_MED);
            DIFF_HARD: return 16'(LIFE_HARD);
            default:   return 16'(LIFE_EASY);
        endcase
    endfunction

    assign lfsr_d     = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    assign rise       = Sw & ~sw_q;
    assign hole_mask  = 9'(1) << idx_q;
    assign wrong_rise = |(rise & ~hole_mask);
    assign active     = (state_q == GAP) || (state_q == PICK) ||
                        (state_q == UP)  || (state_q == HIT);
    // Only LFSR values 1..9 map to holes; the rest are skipped, which keeps the pick unbiased.
    assign pick_ok    = (lfsr_q != 4'd0) && (lfsr_q <= 4'(NUM_HOLES)) &&
                        (first_q || ((lfsr_q - 4'd1) != idx_q));

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        misses_d   = misses_q;
        idx_d      = idx_q;
        ms_d       = ms_q;
        gap_d      = gap_q;
        life_d     = life_q;
        life_sel_d = life_sel_q;
        first_d    = first_q;
        tick_clr   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    life_sel_d = life_for(Diff);
                    score_d    = '0;
                    misses_d   = '0;
                    ms_d       = 16'(GAME_MS);
                    gap_d      = 16'(GAP_MS);
                    first_d    = 1'b1;
                    tick_clr   = 1'b1;
                    state_d    = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    if (gap_q <= 16'd1) begin
                        gap_d   = '0;
                        state_d = PICK;
                    end else begin
                        gap_d = gap_q - 16'd1;
                    end
                end
            end
            PICK: begin
                if (pick_ok) begin
                    idx_d   = lfsr_q - 4'd1;
                    life_d  = life_sel_q;
                    first_d = 1'b0;
                    state_d = UP;
                end
            end
            UP: begin
                if (tick && (life_q != 16'd0)) begin
                    life_d = life_q - 16'd1;
                end
                if (rise == hole_mask) begin
                    state_d = HIT;
                end else if (wrong_rise) begin
                    misses_d = sat_inc7(misses_q);
                end else if (tick && (life_q <= 16'd1)) begin
                    misses_d = sat_inc7(misses_q);
                    gap_d    = 16'(GAP_MS);
                    state_d  = GAP;
                end
            end
            HIT: begin
                score_d = sat_inc7(score_q);
                gap_d   = 16'(GAP_MS);
                state_d = GAP;
            end
            DONE: begin
                if (Ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The final tick ends the round and discards whatever else this cycle decided.
        if (active && tick) begin
            if (ms_q <= 16'd1) begin
                ms_d     = '0;
                state_d  = DONE;
                score_d  = score_q;
                misses_d = misses_q;
                idx_d    = idx_q;
            end else begin
                ms_d = ms_q - 16'd1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            lfsr_q     <= LFSR_SEED;
            sw_q       <= '0;
            score_q    <= '0;
            misses_q   <= '0;
            idx_q      <= '0;
            ms_q       <= '0;
            gap_q      <= '0;
            life_q     <= '0;
            life_sel_q <= '0;
            first_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            sw_q       <= Sw;
            score_q    <= score_d;
            misses_q   <= misses_d;
            idx_q      <= idx_d;
            ms_q       <= ms_d;
            gap_q      <= gap_d;
            life_q     <= life_d;
            life_sel_q <= life_sel_d;
            first_q    <= first_d;
        end
    end

    assign mole_valid  = (state_q == UP);
    assign mole_index  = idx_q;
    assign score       = score_q;
    assign misses      = misses_q;
    assign game_active = active;
    assign game_done   = (state_q == DONE);
    assign ms_left     = ms_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// tb/tb_mole_scheduler.sv - scoreboard bench for mole_scheduler with small timing parameters
module tb_mole_scheduler;
    localparam int TICK_DIV  = 4;
    localparam int GAME_MS   = 40;
    localparam int GAP_MS    = 2;
    localparam int LIFE_EASY = 6;
    localparam int LIFE_MED  = 4;
    localparam int LIFE_HARD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  diff;
    logic        ack;
    logic [8:0]  sw;
    logic        mole_valid;
    logic [3:0]  mole_index;
    logic [6:0]  score;
    logic [6:0]  misses;
    logic        game_active;
    logic        game_done;
    logic [15:0] ms_left;

    int tests_run    = 0;
    int tests_failed = 0;

    int exp_score, exp_misses;
    bit whack_pending, prev_valid, first_pick;
    int cyc_count, t0, last_idx, n_picks;

    always #5 clk = ~clk;

    mole_scheduler #(
        .TICK_DIV (TICK_DIV),
        .GAME_MS  (GAME_MS),
        .GAP_MS   (GAP_MS),
        .LIFE_EASY(LIFE_EASY),
        .LIFE_MED (LIFE_MED),
        .LIFE_HARD(LIFE_HARD)
    ) dut (
        .Clk        (clk),
        .Reset      (rst),
        .Start      (start),
        .Diff       (diff),
        .Ack        (ack),
        .Sw         (sw),
        .mole_valid (mole_valid),
        .mole_index (mole_index),
        .score      (score),
        .misses     (misses),
        .game_active(game_active),
        .game_done  (game_done),
        .ms_left    (ms_left)
    );

    typedef enum int {K_SCORE, K_MISS, K_VALID, K_MS, K_DONE, K_ACT, K_IDX} kind_e;
    typedef struct {
        string tag;
        kind_e kind;
        int    exp;
    } sb_t;
    sb_t sbq[$];

    task automatic check_eq(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat127(input int v);
        return (v >= 127) ? 127 : v + 1;
    endfunction

    function automatic int observe(input kind_e k);
        case (k)
            K_SCORE: return int'(score);
            K_MISS:  return int'(misses);
            K_VALID: return int'(mole_valid);
            K_MS:    return int'(ms_left);
            K_DONE:  return int'(game_done);
            K_ACT:   return int'(game_active);
            default: return int'(mole_index);
        endcase
    endfunction

    task automatic sb_push(input string tag, input kind_e k, input int e);
        sb_t s;
        s.tag  = tag;
        s.kind = k;
        s.exp  = e;
        sbq.push_back(s);
    endtask

    task automatic sb_drain();
        sb_t s;
        while (sbq.size() > 0) begin
            s = sbq.pop_front();
            check_eq(s.tag, observe(s.kind), s.exp);
        end
    endtask

    // One clock; tracks spawns and mole exits so the expected score/misses follow the game.
    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_count++;
        if (!prev_valid && mole_valid) begin
            n_picks++;
            check_eq("pick_range", int'(mole_index <= 4'd8), 1);
            if (!first_pick) check_eq("pick_repeat", int'(mole_index != 4'(last_idx)), 1);
            first_pick = 1'b0;
            last_idx   = int'(mole_index);
        end
        if (prev_valid && !mole_valid) begin
            if (!game_done) begin
                if (whack_pending) exp_score = sat127(exp_score);
                else exp_misses = sat127(exp_misses);
            end
            whack_pending = 1'b0;
        end
        prev_valid = mole_valid;
    endtask

    task automatic start_round(input logic [1:0] d);
        diff       = d;
        start      = 1'b1;
        exp_score  = 0;
        exp_misses = 0;
        first_pick = 1'b1;
        cyc();
        start = 1'b0;
        t0    = cyc_count;
        sb_push("start_ms", K_MS, GAME_MS);
        sb_push("start_active", K_ACT, 1);
        sb_push("start_valid", K_VALID, 0);
        sb_push("start_score", K_SCORE, 0);
        sb_push("start_misses", K_MISS, 0);
        sb_drain();
    endtask

    task automatic wait_mole();
        int n = 0;
        while (!mole_valid && n < 200) begin
            cyc();
            n++;
        end
        if (!mole_valid) check_eq("wait_mole_timeout", 0, 1);
    endtask

    task automatic whack();
        sw            = 9'(1) << mole_index;
        whack_pending = 1'b1;
        cyc();
        sw = '0;
        sb_push("whack_valid_low", K_VALID, 0);
        sb_drain();
    endtask

    initial begin
        int  n, old_idx, up_start, guard;
        bit  was;

        rst = 1'b1; start = 1'b0; ack = 1'b0; sw = '0; diff = 2'd0;
        exp_score = 0; exp_misses = 0; whack_pending = 0; prev_valid = 0;
        first_pick = 1; cyc_count = 0; last_idx = 0; n_picks = 0;
        repeat (3) @(posedge clk);
        #1;
        sb_push("rst_valid", K_VALID, 0);
        sb_push("rst_idx", K_IDX, 0);
        sb_push("rst_score", K_SCORE, 0);
        sb_push("rst_misses", K_MISS, 0);
        sb_push("rst_active", K_ACT, 0);
        sb_push("rst_done", K_DONE, 0);
        sb_push("rst_ms", K_MS, 0);
        sb_drain();
        rst = 1'b0;
        cyc();

        // Hard round with no switches: every mole expires on a tick after two ticks up.
        start_round(2'd2);
        n = 0; was = 1'b0; up_start = 0;
        while (!game_done && n < 300) begin
            cyc();
            n++;
            if (mole_valid && !was) up_start = cyc_count;
            if (!mole_valid && was && !game_done) begin
                check_eq("s1_fall_on_tick", (cyc_count - t0) % TICK_DIV, 0);
                check_eq("s1_up_len", int'((cyc_count - up_start) inside {[TICK_DIV+1:2*TICK_DIV]}), 1);
            end
            was = mole_valid;
        end
        check_eq("s1_done_cycle", cyc_count - t0, GAME_MS * TICK_DIV);
        check_eq("s1_some_expiries", int'(exp_misses > 0), 1);
        sb_push("s1_done", K_DONE, 1);
        sb_push("s1_ms", K_MS, 0);
        sb_push("s1_score", K_SCORE, 0);
        sb_push("s1_misses", K_MISS, exp_misses);
        sb_push("s1_valid", K_VALID, 0);
        sb_push("s1_active", K_ACT, 0);
        sb_drain();
        ack = 1'b1; cyc(); ack = 1'b0;
        sb_push("s1_ack_idle", K_DONE, 0);
        sb_drain();

        // Easy round: clean hit, then gap length and a fresh hole.
        start_round(2'd0);
        wait_mole();
        old_idx = int'(mole_index);
        whack();
        n = 0;
        while (!mole_valid && n < 200) begin
            cyc();
            n++;
        end
        check_eq("s2_gap_len", int'(n >= GAP_MS * TICK_DIV - 1), 1);
        check_eq("s2_new_idx", int'(mole_index != 4'(old_idx)), 1);
        sb_push("s2_score", K_SCORE, exp_score);
        sb_push("s2_score_one", K_SCORE, 1);
        sb_drain();

        // Correct and wrong edge together counts as a miss; mole stays up.
        sw = (9'(1) << mole_index) | (9'(1) << ((mole_index + 4'd1) % 4'd9));
        exp_misses = sat127(exp_misses);
        sb_push("s3_misses", K_MISS, exp_misses);
        sb_push("s3_score", K_SCORE, exp_score);
        sb_push("s3_valid", K_VALID, 1);
        cyc();
        sb_drain();
        sw = '0;
        n = 0;
        while (mole_valid && n < 100) begin
            cyc();
            n++;
        end
        sb_push("s3_expiry_misses", K_MISS, exp_misses);
        sb_drain();

        // Switches held high across a spawn give no edge; release and re-raise scores.
        sw = 9'h1FF;
        cyc();
        wait_mole();
        repeat (3) cyc();
        sb_push("s4_held_score", K_SCORE, exp_score);
        sb_push("s4_held_misses", K_MISS, exp_misses);
        sb_push("s4_held_valid", K_VALID, 1);
        sb_drain();
        sw = '0;
        cyc();
        whack();
        cyc();
        sb_push("s4_hit_score", K_SCORE, exp_score);
        sb_push("s4_hit_score_two", K_SCORE, 2);
        sb_drain();

        // Correct edge landing on the final tick is ignored.
        n = 0;
        while (ms_left != 16'd1 && n < 400) begin
            cyc();
            n++;
        end
        check_eq("s5_reach_last_ms", int'(ms_left), 1);
        repeat (TICK_DIV - 1) cyc();
        sw = mole_valid ? (9'(1) << mole_index) : 9'h001;
        cyc();
        sw = '0;
        sb_push("s5_done", K_DONE, 1);
        sb_push("s5_ms", K_MS, 0);
        sb_push("s5_score", K_SCORE, exp_score);
        sb_push("s5_misses", K_MISS, exp_misses);
        sb_push("s5_valid", K_VALID, 0);
        sb_drain();
        start = 1'b1; cyc(); start = 1'b0; cyc();
        sb_push("s5_start_ignored", K_DONE, 1);
        sb_push("s5_start_ms", K_MS, 0);
        sb_drain();
        ack = 1'b1; cyc(); ack = 1'b0; cyc();
        sb_push("s5_ack_done", K_DONE, 0);
        sb_push("s5_ack_active", K_ACT, 0);
        sb_push("s5_ack_score", K_SCORE, exp_score);
        sb_push("s5_ack_misses", K_MISS, exp_misses);
        sb_drain();

        // Five hits, then asynchronous reset while a mole is up.
        start_round(2'd0);
        repeat (5) begin
            wait_mole();
            whack();
        end
        wait_mole();
        sb_push("s6_score_five", K_SCORE, 5);
        sb_push("s6_score_model", K_SCORE, exp_score);
        sb_push("s6_up", K_VALID, 1);
        sb_drain();
        #2 rst = 1'b1;
        #1;
        sb_push("s6_rst_valid", K_VALID, 0);
        sb_push("s6_rst_idx", K_IDX, 0);
        sb_push("s6_rst_score", K_SCORE, 0);
        sb_push("s6_rst_misses", K_MISS, 0);
        sb_push("s6_rst_active", K_ACT, 0);
        sb_push("s6_rst_done", K_DONE, 0);
        sb_push("s6_rst_ms", K_MS, 0);
        sb_drain();
        @(posedge clk);
        #1;
        rst = 1'b0;
        prev_valid = 1'b0;
        whack_pending = 1'b0;
        cyc();
        start_round(2'd1);

        // Random play until 200 picks have been checked.
        n_picks = 0;
        guard = 0;
        while (n_picks < 200 && guard < 20000) begin
            if (game_done) begin
                sb_push("rnd_end_score", K_SCORE, exp_score);
                sb_push("rnd_end_misses", K_MISS, exp_misses);
                sb_push("rnd_end_ms", K_MS, 0);
                sb_drain();
                ack = 1'b1; cyc(); ack = 1'b0;
                start_round(2'($urandom_range(0, 3)));
            end else if (mole_valid && ms_left > 16'd3 && $urandom_range(0, 1) == 1) begin
                whack();
            end else begin
                cyc();
            end
            guard++;
        end
        check_eq("rnd_pick_count", int'(n_picks >= 200), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
Game sequencer for the whack-a-mole core. It owns the round timer, the mole up/down cadence, unbiased random hole selection, and hit/miss scoring from the nine hole switches. Its outputs (mole_valid, mole_index, score, misses, time left) feed the VGA renderer and score display. It replaces ad-hoc free-running timers with one tick-driven FSM.

Parameters:
TICK_DIV, 100000, Clk cycles per 1 ms tick (100 MHz); must be ≥ 2.
GAME_MS, 60000, round length in ticks; must be ≤ 65535.
GAP_MS, 250, ticks with no mole between spawns.
LIFE_EASY, 3000, mole lifetime in ticks, Diff=0.
LIFE_MED, 2000, mole lifetime in ticks, Diff=1.
LIFE_HARD, 1000, mole lifetime in ticks, Diff=2.

Ports:
Clk  in  1  system clock, 100 MHz.
Reset  in  1  asynchronous, active-high reset.
Start  in  1  single-cycle pulse; starts a round from IDLE.
Diff  in  2  difficulty, sampled at Start: 0 easy, 1 medium, 2 hard, 3 treated as easy.
Ack  in  1  returns DONE to IDLE.
Sw  in  9  hole switches, already synchronised and debounced upstream.
mole_valid  out  1  a mole is up at mole_index.
mole_index  out  4  current hole, 0..8.
score  out  7  hits, saturating at 127.
misses  out  7  expiries plus wrong whacks, saturating at 127.
game_active  out  1  high in GAP, PICK, UP, HIT.
game_done  out  1  high in DONE.
ms_left  out  16  ticks remaining in the round.

Behaviour:
- Reset (asynchronous, active-high) forces all outputs to 0, state to IDLE, LFSR to 4'b1011, prescaler to 0, and the Sw history register to 0. Reset mid-round aborts the round with no residual state.
- LFSR: 4-bit, x^4+x^3+1, next = {l[2:0], l[3]^l[2]}. It advances every cycle in all states and is never zero.
- Tick: prescaler counts 0..TICK_DIV-1 and pulses tick on wrap. It is cleared on the accepted Start, so the first tick arrives exactly TICK_DIV cycles after Start.
- Edge detect: rise = Sw & ~Sw_q, with Sw_q registered every cycle.
- IDLE:
  - Start=1 → latch life from Diff; clear score and misses; ms_left=GAME_MS; gap counter=GAP_MS; go to GAP.
  - Start is ignored in every other state.
- GAP:
  - mole_valid=0.
  - Each tick decrements the gap counter; reaching 0 → PICK.
- PICK:
  - Accept when LFSR ∈ 1..9 and (LFSR-1) ≠ previous mole_index. Otherwise retry next cycle.
  - On accept: mole_index ← LFSR-1; life counter ← latched life; go to UP.
  - Maximum PICK dwell is 15 cycles.
  - The first pick of a round has no repeat restriction.
- UP (mole_valid=1), evaluated in this priority order:
  1. rise[mole_index]=1 and no other rise bit → HIT.
  2. Any other rise bit (including a correct edge coincident with a wrong one) → misses+1, stay in UP.
  3. Life counter reaches 0 on a tick → misses+1, gap counter ← GAP_MS, go to GAP.
  - A hit in the same cycle as expiry counts as a hit.
- HIT: one cycle; mole_valid=0; score+1; gap counter ← GAP_MS; go to GAP.
- Round timer:
  - In GAP, PICK, UP and HIT, each tick decrements ms_left.
  - When ms_left=1 and a tick arrives, ms_left becomes 0 and the state goes to DONE that cycle.
  - This end condition overrides all other transitions; a hit or miss in that cycle is not counted.
- DONE:
  - mole_valid=0; score and misses are held.
  - Ack=1 → IDLE, with score, misses and mole_index held until the next Start.
- Counter widths: score and misses saturate at 127 (no wrap). ms_left never underflows.
- mole_index holds its value while mole_valid=0.

Decomposition:
- whackamole_pkg holds:
  - state encoding: IDLE, GAP, PICK, UP, HIT, DONE, one-hot 6-bit;
  - difficulty codes DIFF_EASY, DIFF_MED, DIFF_HARD;
  - LFSR_SEED=4'b1011;
  - NUM_HOLES=9.
- Sub-module mole_tick_gen (parameter TICK_DIV; inputs Clk, Reset, clr; output tick) holds the prescaler.
- The FSM, LFSR, edge detect and counters stay in mole_scheduler.

Test Plan:
All scenarios use bench parameters TICK_DIV=4, GAME_MS=40, GAP_MS=2, LIFE_EASY=6, LIFE_MED=4, LIFE_HARD=2.
- Reset, Start with Diff=2, no switches → mole_valid high for 2 ticks per spawn; misses increments each expiry; DONE after 160 cycles (+1) with ms_left=0, game_done=1, score=0.
- Diff=0, in UP toggle Sw bit mole_index 0→1 → next cycle HIT, score=1, mole_valid=0 for at least GAP_MS ticks; the next mole_index differs from the previous one.
- In UP, raise the correct bit and one wrong bit in the same cycle → misses+1, score unchanged, mole stays up.
- Hold the correct Sw bit high across a spawn → no hit (no rising edge); clear and re-raise it → hit.
- Raise a correct edge in the same cycle as the final tick → DONE, score unchanged; Ack → IDLE with score held; Start pulses in DONE are ignored.
- Assert Reset mid-UP with score=5 → all outputs 0 at once, state IDLE; a new Start round runs normally from ms_left=40; 200 random picks all give mole_index ≤ 8.
